// File: rtl/vga_timing_pkg.sv
// Nominal 640x480 VGA timing constants and the receiver lock-state encoding,
// shared between the display transmitter and the sync receiver.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BACK  = 144;
    localparam int unsigned V_TOTAL = 525;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BACK  = 35;

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input, keeps a delayed copy and flags rising/falling edges.
// Both stages reset high so an idle (high) sync line never produces an edge.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;
    logic sig_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q     <= 1'b1;
            sig_dly_q <= 1'b1;
        end else begin
            sig_q     <= sig_i;
            sig_dly_q <= sig_q;
        end
    end

    assign rise_o = sig_q & ~sig_dly_q;
    assign fall_o = ~sig_q & sig_dly_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from hSync/vSync, checks line and frame timing and
// tracks lock to the incoming stream.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hSync,
    input  logic        vSync,
    input  logic        bright,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        brightOut,
    output logic        locked,
    output logic        hErr,
    output logic        vErr,
    output logic [15:0] frameCount,
    output logic [7:0]  errCount
);

    localparam int unsigned HShift     = $clog2(CLK_DIV);
    localparam logic [12:0] HLineClks  = 13'(H_TOTAL * CLK_DIV);
    localparam logic [12:0] HSyncClks  = 13'(H_SYNC * CLK_DIV);
    localparam logic [10:0] VLines     = 11'(V_TOTAL);
    localparam logic [10:0] VSyncLines = 11'(V_SYNC);

    logic        h_rise, h_fall, v_rise, v_fall;
    logic [11:0] h_clk_q, h_clk_d;
    logic [9:0]  v_line_q, v_line_d;
    logic        h_arm_q, v_arm_q;
    logic        h_err_q, h_err_d, v_err_q, v_err_d;
    logic [1:0]  bright_q;
    lock_state_e state_q;
    logic [7:0]  gf_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;
    logic [12:0] h_clk_inc;
    logic [10:0] v_line_seen;
    logic        h_sat, err_in, enter_search;

    sync_edge_detect u_h_edge (
        .clk_i  (clk),
        .rst_ni (rst),
        .sig_i  (hSync),
        .rise_o (h_rise),
        .fall_o (h_fall)
    );

    sync_edge_detect u_v_edge (
        .clk_i  (clk),
        .rst_ni (rst),
        .sig_i  (vSync),
        .rise_o (v_rise),
        .fall_o (v_fall)
    );

    always_comb begin
        h_sat     = (h_clk_q == 12'hFFF);
        h_clk_inc = {1'b0, h_clk_q} + 13'd1;
        // A coincident hSync fall closes the line in progress, so it counts toward vSync checks.
        v_line_seen = {1'b0, v_line_q} + {10'd0, h_fall};

        h_err_d = h_arm_q & ((h_fall & (h_clk_inc != HLineClks)) |
                             (h_rise & (h_clk_inc != HSyncClks)));
        v_err_d = v_arm_q & ((v_fall & (v_line_seen != VLines)) |
                             (v_rise & (v_line_seen != VSyncLines)));

        h_clk_d = h_clk_q;
        if (h_fall) begin
            h_clk_d = '0;
        end else if (!h_sat) begin
            h_clk_d = h_clk_q + 12'd1;
        end

        v_line_d = v_line_q;
        if (v_fall) begin
            v_line_d = '0;
        end else if (h_fall && (v_line_q != 10'h3FF)) begin
            v_line_d = v_line_q + 10'd1;
        end

        err_in       = h_err_q | v_err_q;
        enter_search = err_in & (state_q != StSearch);
    end

    // Edge checks stay disarmed until a first falling edge gives a trustworthy reference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_clk_q  <= '0;
            v_line_q <= '0;
            h_err_q  <= 1'b0;
            v_err_q  <= 1'b0;
            h_arm_q  <= 1'b0;
            v_arm_q  <= 1'b0;
            bright_q <= '0;
        end else begin
            h_clk_q  <= h_clk_d;
            v_line_q <= v_line_d;
            h_err_q  <= h_err_d;
            v_err_q  <= v_err_d;
            bright_q <= {bright_q[0], bright};
            if (enter_search) begin
                h_arm_q <= 1'b0;
            end else if (h_fall) begin
                h_arm_q <= 1'b1;
            end
            if (v_fall) begin
                v_arm_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StSearch;
            gf_q        <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                StSearch: begin
                    if (v_fall && !err_in) begin
                        state_q <= StAcquire;
                        gf_q    <= '0;
                    end
                end
                StAcquire: begin
                    if (err_in) begin
                        state_q <= StSearch;
                    end else if (v_fall) begin
                        gf_q <= gf_q + 8'd1;
                        if (32'(gf_q) + 32'd1 >= LOCK_FRAMES) begin
                            state_q     <= StLocked;
                            frame_cnt_q <= '0;
                        end
                    end
                end
                StLocked: begin
                    if (err_in) begin
                        state_q <= StSearch;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else if (v_fall) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

    assign hCount     = h_sat ? 10'h3FF : 10'(h_clk_q >> HShift);
    assign vCount     = v_line_q;
    assign brightOut  = bright_q[1];
    assign locked     = (state_q == StLocked);
    assign hErr       = h_err_q;
    assign vErr       = v_err_q;
    assign frameCount = frame_cnt_q;
    assign errCount   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down raster (20x10 pixels,
// 2 clk per pixel) so several full frames fit in a short run.
module tb_vga_sync_receiver;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned H_TOTAL     = 20;
    localparam int unsigned H_SYNC      = 4;
    localparam int unsigned V_TOTAL     = 10;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned LOCK_FRAMES = 2;
    localparam int LineClks  = H_TOTAL * CLK_DIV;
    localparam int HSyncClks = H_SYNC * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        hSync, vSync, bright;
    logic [9:0]  hCount, vCount;
    logic        brightOut, locked, hErr, vErr;
    logic [15:0] frameCount;
    logic [7:0]  errCount;

    int n_checks, n_fail, herr_seen, verr_seen;
    int tx_k, tx_line, cur_k, cur_line, vs_width;
    bit idle, short_on;

    vga_sync_receiver #(
        .CLK_DIV     (CLK_DIV),
        .H_TOTAL     (H_TOTAL),
        .H_SYNC      (H_SYNC),
        .V_TOTAL     (V_TOTAL),
        .V_SYNC      (V_SYNC),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hSync      (hSync),
        .vSync      (vSync),
        .bright     (bright),
        .hCount     (hCount),
        .vCount     (vCount),
        .brightOut  (brightOut),
        .locked     (locked),
        .hErr       (hErr),
        .vErr       (vErr),
        .frameCount (frameCount),
        .errCount   (errCount)
    );

    always #5 clk = ~clk;

    // Samples after the edge, then drives the transmitter pins for the coming cycle.
    task automatic tick();
        int len;
        @(posedge clk);
        #1;
        herr_seen += int'(hErr);
        verr_seen += int'(vErr);
        if (idle) begin
            hSync  = 1'b1;
            vSync  = 1'b1;
            bright = 1'b0;
        end else begin
            cur_k    = tx_k;
            cur_line = tx_line;
            hSync    = (tx_k >= HSyncClks);
            vSync    = (tx_line >= vs_width);
            bright   = (tx_k >= 12 && tx_k < 36 && tx_line >= 3 && tx_line < 9);
            len      = (short_on && tx_line == 7) ? LineClks - 4 : LineClks;
            tx_k++;
            if (tx_k >= len) begin
                tx_k = 0;
                if (tx_line == 7) short_on = 1'b0;
                tx_line = (tx_line + 1) % V_TOTAL;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int k, input int line);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cur_k == k && cur_line == line) return;
        end
        n_checks++;
        n_fail++;
        $error("FAIL run_to: observed timeout, expected k=%0d line=%0d", k, line);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; herr_seen = 0; verr_seen = 0;
        tx_k = 0; tx_line = 0; cur_k = -1; cur_line = -1;
        vs_width = V_SYNC; idle = 1'b1; short_on = 1'b0;
        hSync = 1'b1; vSync = 1'b1; bright = 1'b0; rst = 1'b0;

        repeat (3) tick();
        check("reset hCount", 32'(hCount), 0);
        check("reset vCount", 32'(vCount), 0);
        check("reset locked", 32'(locked), 0);
        check("reset hErr", 32'(hErr), 0);
        check("reset vErr", 32'(vErr), 0);
        check("reset brightOut", 32'(brightOut), 0);
        check("reset frameCount", 32'(frameCount), 0);
        check("reset errCount", 32'(errCount), 0);

        // Nominal stream: vSync falls at ticks 1, 401, 801, 1201.
        rst = 1'b1;
        idle = 1'b0;
        repeat (802) tick();
        check("locked before 3rd fall+2", 32'(locked), 0);
        tick();
        check("locked at 3rd fall+2", 32'(locked), 1);
        check("frameCount at lock", 32'(frameCount), 0);
        repeat (399) tick();
        check("frameCount before 4th fall", 32'(frameCount), 0);
        tick();
        check("frameCount after 4th fall", 32'(frameCount), 1);
        check("no hErr nominal", 32'(herr_seen), 0);
        check("no vErr nominal", 32'(verr_seen), 0);

        // Pixel (12,5) is inside the bright window, (2,6) is not.
        run_to(24, 5);
        repeat (2) tick();
        check("hCount at px 12", 32'(hCount), 12);
        check("vCount at line 5", 32'(vCount), 5);
        check("brightOut inside", 32'(brightOut), 1);
        run_to(4, 6);
        repeat (2) tick();
        check("hCount at px 2", 32'(hCount), 2);
        check("vCount at line 6", 32'(vCount), 6);
        check("brightOut outside", 32'(brightOut), 0);

        // Line 7 shortened by 4 clk while locked.
        herr_seen = 0; verr_seen = 0;
        run_to(0, 7);
        short_on = 1'b1;
        run_to(0, 8);
        tick();
        check("hErr before short check", 32'(hErr), 0);
        tick();
        check("hErr short line", 32'(hErr), 1);
        check("locked with hErr", 32'(locked), 1);
        tick();
        check("hErr one cycle", 32'(hErr), 0);
        check("locked drops", 32'(locked), 0);
        check("errCount after drop", 32'(errCount), 1);

        // vSync held low 3 lines while in ACQUIRE.
        run_to(0, 0);
        vs_width = 3;
        repeat (2) tick();
        check("locked in acquire", 32'(locked), 0);
        run_to(0, 3);
        tick();
        check("vErr before rise check", 32'(vErr), 0);
        tick();
        check("vErr wide vsync", 32'(vErr), 1);
        check("locked during vErr", 32'(locked), 0);
        tick();
        check("errCount unchanged", 32'(errCount), 1);
        vs_width = V_SYNC;
        run_to(0, 0);
        run_to(0, 0);
        repeat (2) tick();
        check("no lock after 1 good frame", 32'(locked), 0);
        run_to(0, 0);
        tick();
        check("no lock at fall+1", 32'(locked), 0);
        tick();
        check("relock", 32'(locked), 1);
        check("hErr count", 32'(herr_seen), 1);
        check("vErr count", 32'(verr_seen), 1);

        // Asynchronous reset mid-frame while locked.
        run_to(0, 0);
        repeat (2) tick();
        check("frameCount one frame", 32'(frameCount), 1);
        run_to(0, 4);
        #3;
        rst = 1'b0;
        #1;
        check("async rst locked", 32'(locked), 0);
        check("async rst errCount", 32'(errCount), 0);
        check("async rst frameCount", 32'(frameCount), 0);
        check("async rst hCount", 32'(hCount), 0);
        check("async rst vCount", 32'(vCount), 0);
        repeat (15) tick();
        rst = 1'b1;
        herr_seen = 0; verr_seen = 0;
        run_to(0, 0);
        run_to(0, 0);
        repeat (2) tick();
        check("post-rst no lock 1", 32'(locked), 0);
        run_to(0, 0);
        tick();
        check("post-rst no lock 2", 32'(locked), 0);
        tick();
        check("post-rst relock", 32'(locked), 1);
        check("post-rst hErr", 32'(herr_seen), 0);
        check("post-rst vErr", 32'(verr_seen), 0);

        // Sync lines stuck high.
        run_to(20, 5);
        idle = 1'b1;
        repeat (5000) tick();
        check("idle hCount saturated", 32'(hCount), 1023);
        check("idle vCount held", 32'(vCount), 5);
        check("idle locked held", 32'(locked), 1);
        check("idle no hErr", 32'(herr_seen), 0);
        check("idle no vErr", 32'(verr_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
